// File: rtl/nap_duration_entry_pkg.sv
// Shared types and constants for the nap-duration keypad front end.
package nap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Preset increments expressed in seconds; the adder handles the m:ss carry.
    localparam logic [6:0] PRESET_5S  = 7'd5;
    localparam logic [6:0] PRESET_30S = 7'd30;
    localparam logic [6:0] PRESET_1M  = 7'd60;

    localparam bcd_t KEY_5S  = 4'd1;
    localparam bcd_t KEY_30S = 4'd2;
    localparam bcd_t KEY_1M  = 4'd3;

    function automatic bcd_t key_value(input logic [9:0] keys);
        bcd_t v;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) v = bcd_t'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/nap_duration_entry_if.sv
// Keypad-side and countdown-side signals of the nap-duration entry block.
interface nap_duration_entry_if #(
    parameter int MIN_DIGITS = 1
);
    localparam int ND = MIN_DIGITS + 2;

    logic              en;
    logic              direct_mode;
    logic [9:0]        keypad;
    logic              sharp;
    logic              star;
    logic [4*ND-1:0]   pend_bcd;
    logic [4*ND-1:0]   time_bcd;
    logic              complete_setting;
    logic              entry_error;
    logic              timeout;
    logic              busy;

    modport master (
        output en, direct_mode, keypad, sharp, star,
        input  pend_bcd, time_bcd, complete_setting, entry_error, timeout, busy
    );

    modport slave (
        input  en, direct_mode, keypad, sharp, star,
        output pend_bcd, time_bcd, complete_setting, entry_error, timeout, busy
    );

endinterface

// File: rtl/nap_duration_entry_bcd_time_adder.sv
// Adds a preset (in seconds) to a BCD m..m:ss value, carrying seconds at 60
// and saturating at 9..9:59.
module bcd_time_adder
    import nap_pkg::*;
#(
    parameter int MIN_DIGITS = 1
) (
    input  logic [4*(MIN_DIGITS+2)-1:0] i_time,
    input  logic [6:0]                  i_add_sec,
    output logic [4*(MIN_DIGITS+2)-1:0] o_sum
);
    localparam int ND = MIN_DIGITS + 2;
    localparam int W  = 4 * ND;

    function automatic logic [W-1:0] saturate(input logic overflow, input logic [W-1:0] value);
        logic [W-1:0] max_v;
        max_v = '0;
        for (int d = 0; d < ND; d++) max_v[4*d +: 4] = 4'd9;
        max_v[7:4] = 4'd5;
        return overflow ? max_v : value;
    endfunction

    logic [7:0]   w_sec_raw;
    logic [7:0]   w_sec;
    logic         w_sec_carry;
    logic         w_carry;
    logic [4:0]   w_digit;
    logic [W-1:0] w_res;

    always_comb begin
        w_sec_raw   = 8'(i_time[7:4]) * 8'd10 + 8'(i_time[3:0]) + 8'(i_add_sec);
        w_sec_carry = (w_sec_raw >= 8'd60);
        w_sec       = w_sec_carry ? (w_sec_raw - 8'd60) : w_sec_raw;
        w_res       = '0;
        w_res[7:4]  = 4'(w_sec / 8'd10);
        w_res[3:0]  = 4'(w_sec % 8'd10);
        w_carry     = w_sec_carry;
        w_digit     = '0;
        // Minute digits only ever see a +1 carry, so a simple ripple suffices.
        for (int d = 2; d < ND; d++) begin
            w_digit = 5'(i_time[4*d +: 4]) + 5'(w_carry);
            w_carry = (w_digit > 5'd9);
            w_res[4*d +: 4] = w_carry ? 4'(w_digit - 5'd10) : w_digit[3:0];
        end
        o_sum = saturate(w_carry, w_res);
    end

endmodule

// File: rtl/nap_duration_entry.sv
// Keypad front end for the nap timer: qualifies key/#/* presses, builds a BCD
// duration in preset or direct mode, and commits it on a valid confirm.
module nap_duration_entry
    import nap_pkg::*;
#(
    parameter int          MIN_DIGITS     = 1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                clock,
    input  logic                reset,
    nap_duration_entry_if.slave bus
);
    localparam int ND = MIN_DIGITS + 2;
    localparam int W  = 4 * ND;

    state_t       r_state;
    logic         r_mode;
    logic [9:0]   r_key_p0, r_key_p1;
    logic         r_sharp_p0, r_sharp_p1, r_star_p0, r_star_p1;
    logic [W-1:0] r_pend, r_time;
    logic         r_complete, r_error, r_timeout, r_busy;
    logic [15:0]  r_idle;

    logic [9:0]   w_key_rise;
    logic         w_key_ok, w_sharp_rise, w_star_rise, w_press;
    logic         w_mode, w_invalid, w_expired;
    bcd_t         w_key_val;
    logic [6:0]   w_add_sec;
    logic [W-1:0] w_sum, w_next_digit;
    logic [15:0]  w_idle_next;

    assign w_key_rise   = r_key_p0 & ~r_key_p1;
    assign w_key_ok     = $onehot(w_key_rise);
    assign w_sharp_rise = r_sharp_p0 & ~r_sharp_p1;
    assign w_star_rise  = r_star_p0 & ~r_star_p1;
    assign w_press      = w_star_rise | w_sharp_rise | w_key_ok;
    assign w_key_val    = key_value(w_key_rise);
    // The first press out of IDLE is handled with the mode it latches.
    assign w_mode       = (r_state == ST_IDLE) ? bus.direct_mode : r_mode;
    assign w_invalid    = (r_pend[7:4] > 4'd5) || (r_pend == '0);
    assign w_idle_next  = r_idle + 16'd1;
    assign w_expired    = (TIMEOUT_CYCLES != 16'd0) && (w_idle_next == TIMEOUT_CYCLES);

    always_comb begin
        w_add_sec = '0;
        case (w_key_val)
            KEY_5S:  w_add_sec = PRESET_5S;
            KEY_30S: w_add_sec = PRESET_30S;
            KEY_1M:  w_add_sec = PRESET_1M;
            default: w_add_sec = '0;
        endcase
    end

    bcd_time_adder #(.MIN_DIGITS(MIN_DIGITS)) u_adder (
        .i_time    (r_pend),
        .i_add_sec (w_add_sec),
        .o_sum     (w_sum)
    );

    assign w_next_digit = w_mode ? {r_pend[W-5:0], w_key_val} : w_sum;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_key_p0   <= '0;
            r_key_p1   <= '0;
            r_sharp_p0 <= 1'b0;
            r_sharp_p1 <= 1'b0;
            r_star_p0  <= 1'b0;
            r_star_p1  <= 1'b0;
            r_pend     <= '0;
            r_time     <= '0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_idle     <= '0;
        end else begin
            r_key_p0   <= bus.keypad;
            r_key_p1   <= r_key_p0;
            r_sharp_p0 <= bus.sharp;
            r_sharp_p1 <= r_sharp_p0;
            r_star_p0  <= bus.star;
            r_star_p1  <= r_star_p0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            if (!bus.en) begin
                r_state <= ST_IDLE;
                r_pend  <= '0;
                r_idle  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_DONE: begin
                        r_time     <= r_pend;
                        r_complete <= 1'b1;
                        r_pend     <= '0;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        if (w_press) begin
                            r_mode  <= w_mode;
                            r_idle  <= '0;
                            r_state <= ST_ENTRY;
                            r_busy  <= 1'b1;
                            if (w_star_rise) begin
                                r_pend <= '0;
                            end else if (w_sharp_rise) begin
                                if (w_invalid) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_pend <= w_next_digit;
                            end
                        end else if (r_state == ST_ENTRY) begin
                            if (w_expired) begin
                                r_state   <= ST_IDLE;
                                r_pend    <= '0;
                                r_idle    <= '0;
                                r_busy    <= 1'b0;
                                r_timeout <= 1'b1;
                            end else begin
                                r_idle <= w_idle_next;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.pend_bcd         = r_pend;
    assign bus.time_bcd         = r_time;
    assign bus.complete_setting = r_complete;
    assign bus.entry_error      = r_error;
    assign bus.timeout          = r_timeout;
    assign bus.busy             = r_busy;

endmodule

// File: tb/tb_nap_duration_entry.sv
// Bench for nap_duration_entry: directed table, timing sequences, then random
// stimulus against a seconds/digit-level reference model.
module tb_nap_duration_entry;

    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    nap_duration_entry_if #(.MIN_DIGITS(1)) bus ();

    nap_duration_entry #(.MIN_DIGITS(1), .TIMEOUT_CYCLES(16'd8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic        dm;
        logic [9:0]  key;
        logic        sh;
        logic        st;
        logic [11:0] pend;
        logic [11:0] tm;
        logic        busy;
        logic        err;
    } row_t;

    row_t tbl[$];

    // Reference model state: digits as integers, preset sums done in seconds.
    int          m_d[3];
    int          m_state;
    int          m_idle;
    bit          m_mode, m_busy, m_cmp, m_err, m_to;
    logic [11:0] m_time;
    logic [9:0]  h_key1, h_key2;
    bit          h_sh1, h_sh2, h_st1, h_st2;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] k(input int i);
        return 10'd1 << i;
    endfunction

    function automatic logic [31:0] pack(input logic [11:0] p, input logic [11:0] t,
                                         input logic b, input logic c, input logic e, input logic o);
        return {4'h0, p, t, b, c, e, o};
    endfunction

    function automatic logic [31:0] outs();
        return {4'h0, bus.pend_bcd, bus.time_bcd, bus.busy, bus.complete_setting,
                bus.entry_error, bus.timeout};
    endfunction

    function automatic row_t mk(input logic en, input logic dm, input logic [9:0] key,
                                input logic sh, input logic st, input logic [11:0] p,
                                input logic [11:0] t, input logic b, input logic e);
        row_t r;
        r.en = en; r.dm = dm; r.key = key; r.sh = sh; r.st = st;
        r.pend = p; r.tm = t; r.busy = b; r.err = e;
        return r;
    endfunction

    task automatic press(input logic [9:0] key, input logic sh, input logic st);
        bus.keypad = key; bus.sharp = sh; bus.star = st;
        step();
        bus.keypad = '0; bus.sharp = 1'b0; bus.star = 1'b0;
        step();
    endtask

    function automatic logic [11:0] m_pend();
        return 12'(m_d[2] * 256 + m_d[1] * 16 + m_d[0]);
    endfunction

    task automatic m_clear();
        m_d[0] = 0; m_d[1] = 0; m_d[2] = 0;
    endtask

    task automatic model_reset();
        m_clear();
        m_state = 0; m_idle = 0; m_mode = 0; m_busy = 0;
        m_cmp = 0; m_err = 0; m_to = 0; m_time = '0;
        h_key1 = '0; h_key2 = '0; h_sh1 = 0; h_sh2 = 0; h_st1 = 0; h_st2 = 0;
    endtask

    // Advances the model across one rising edge using the inputs now driven.
    task automatic model_step();
        logic [9:0] rise;
        bit pk, psh, pst;
        int v, t;
        rise = h_key1 & ~h_key2;
        pk   = ($countones(rise) == 1);
        psh  = h_sh1 && !h_sh2;
        pst  = h_st1 && !h_st2;
        m_cmp = 0; m_err = 0; m_to = 0;
        if (!bus.en) begin
            m_state = 0; m_idle = 0; m_clear();
        end else if (m_state == 2) begin
            m_time = m_pend(); m_cmp = 1; m_clear(); m_state = 0;
        end else if (pk || psh || pst) begin
            if (m_state == 0) m_mode = bus.direct_mode;
            m_state = 1; m_idle = 0;
            if (pst) begin
                m_clear();
            end else if (psh) begin
                if (m_d[1] > 5 || m_pend() == 12'h000) m_err = 1;
                else m_state = 2;
            end else begin
                v = 0;
                for (int i = 0; i < 10; i++) if (rise[i]) v = i;
                if (m_mode) begin
                    m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = v;
                end else begin
                    t = m_d[2] * 60 + m_d[1] * 10 + m_d[0];
                    if (v == 1) t += 5;
                    else if (v == 2) t += 30;
                    else if (v == 3) t += 60;
                    if (t > 599) t = 599;
                    m_d[2] = t / 60; m_d[1] = (t % 60) / 10; m_d[0] = t % 10;
                end
            end
        end else if (m_state == 1) begin
            m_idle++;
            if (m_idle == TO) begin
                m_to = 1; m_state = 0; m_idle = 0; m_clear();
            end
        end
        m_busy = (m_state == 1);
        h_key2 = h_key1; h_key1 = bus.keypad;
        h_sh2 = h_sh1;   h_sh1 = bus.sharp;
        h_st2 = h_st1;   h_st1 = bus.star;
    endtask

    initial begin
        int sel;
        reset = 1'b0;
        bus.en = 1'b0; bus.direct_mode = 1'b0; bus.keypad = '0; bus.sharp = 1'b0; bus.star = 1'b0;
        step();
        step();
        chk("reset_state", outs(), pack(12'h000, 12'h000, 0, 0, 0, 0));
        reset = 1'b1;

        // Preset accumulate, commit, direct entry, rejected confirm, clear, abort, saturation.
        tbl.push_back(mk(1, 0, k(1), 0, 0, 12'h005, 12'h000, 1, 0));
        tbl.push_back(mk(1, 0, k(2), 0, 0, 12'h035, 12'h000, 1, 0));
        tbl.push_back(mk(1, 0, k(3), 0, 0, 12'h135, 12'h000, 1, 0));
        tbl.push_back(mk(1, 0, k(1), 0, 0, 12'h140, 12'h000, 1, 0));
        tbl.push_back(mk(1, 0, '0,   1, 0, 12'h140, 12'h000, 0, 0));
        tbl.push_back(mk(1, 1, k(2), 0, 0, 12'h002, 12'h140, 1, 0));
        tbl.push_back(mk(1, 1, k(4), 0, 0, 12'h024, 12'h140, 1, 0));
        tbl.push_back(mk(1, 1, k(5), 0, 0, 12'h245, 12'h140, 1, 0));
        tbl.push_back(mk(1, 1, '0,   1, 0, 12'h245, 12'h140, 0, 0));
        tbl.push_back(mk(1, 1, k(1), 0, 0, 12'h001, 12'h245, 1, 0));
        tbl.push_back(mk(1, 1, k(7), 0, 0, 12'h017, 12'h245, 1, 0));
        tbl.push_back(mk(1, 1, k(0), 0, 0, 12'h170, 12'h245, 1, 0));
        tbl.push_back(mk(1, 1, '0,   1, 0, 12'h170, 12'h245, 1, 1));
        tbl.push_back(mk(1, 1, '0,   0, 1, 12'h000, 12'h245, 1, 0));
        tbl.push_back(mk(0, 0, '0,   0, 0, 12'h000, 12'h245, 0, 0));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1, 0, k(3), 0, 0, (i < 9) ? 12'((i + 1) * 256) : 12'h959, 12'h245, 1, 0));
        tbl.push_back(mk(1, 0, '0,   0, 1, 12'h000, 12'h245, 1, 0));
        tbl.push_back(mk(1, 0, 10'b0000000110, 0, 0, 12'h000, 12'h245, 1, 0));

        foreach (tbl[i]) begin
            bus.en = tbl[i].en;
            bus.direct_mode = tbl[i].dm;
            press(tbl[i].key, tbl[i].sh, tbl[i].st);
            chk($sformatf("row%0d", i), outs(),
                pack(tbl[i].pend, tbl[i].tm, tbl[i].busy, 1'b0, tbl[i].err, 1'b0));
        end

        // Held key: one add only, then the idle timer expires with the key still down.
        bus.en = 1'b0;
        step();
        bus.en = 1'b1; bus.direct_mode = 1'b0; bus.keypad = k(1);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 2) chk("held_first", outs(), pack(12'h005, 12'h245, 1, 0, 0, 0));
            if (c == 9) chk("held_once", outs(), pack(12'h005, 12'h245, 1, 0, 0, 0));
            if (c == 10) chk("held_timeout", outs(), pack(12'h000, 12'h245, 0, 0, 0, 1));
            if (c == 11) chk("held_to_width", outs(), pack(12'h000, 12'h245, 0, 0, 0, 0));
            if (c == 20) chk("held_idle", outs(), pack(12'h000, 12'h245, 0, 0, 0, 0));
        end
        bus.keypad = '0;
        step();

        // Plain press followed by eight idle cycles.
        press(k(1), 0, 0);
        repeat (7) step();
        chk("to_before", outs(), pack(12'h005, 12'h245, 1, 0, 0, 0));
        step();
        chk("to_fire", outs(), pack(12'h000, 12'h245, 0, 0, 0, 1));

        // Commit timing: DONE one edge after detection, strobe on the next.
        press(k(3), 0, 0);
        chk("commit_pend", outs(), pack(12'h100, 12'h245, 1, 0, 0, 0));
        bus.sharp = 1'b1;
        step();
        bus.sharp = 1'b0;
        step();
        chk("commit_done", outs(), pack(12'h100, 12'h245, 0, 0, 0, 0));
        step();
        chk("commit_pulse", outs(), pack(12'h000, 12'h100, 0, 1, 0, 0));
        step();
        chk("commit_width", outs(), pack(12'h000, 12'h100, 0, 0, 0, 0));

        // en drops on the cycle the confirm edge is seen: abort, no commit.
        press(k(1), 0, 0);
        bus.sharp = 1'b1;
        step();
        bus.sharp = 1'b0; bus.en = 1'b0;
        step();
        chk("abort_sharp", outs(), pack(12'h000, 12'h100, 0, 0, 0, 0));
        step();
        chk("abort_nocommit", outs(), pack(12'h000, 12'h100, 0, 0, 0, 0));
        bus.en = 1'b1;

        // Reset in the middle of an entry wipes the committed value too.
        press(k(2), 0, 0);
        chk("pre_reset", outs(), pack(12'h030, 12'h100, 1, 0, 0, 0));
        reset = 1'b0;
        step();
        chk("mid_reset", outs(), pack(12'h000, 12'h000, 0, 0, 0, 0));

        // Random stimulus against the reference model.
        model_reset();
        step();
        reset = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 5) bus.keypad = 10'd1 << $urandom_range(0, 4);
                else if (sel < 8) bus.keypad = '0;
                else if (sel == 8) bus.keypad = 10'd1 << $urandom_range(0, 9);
                else bus.keypad = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
            end
            bus.sharp = ($urandom_range(0, 11) == 0);
            bus.star = ($urandom_range(0, 29) == 0);
            bus.en = ($urandom_range(0, 59) != 0);
            bus.direct_mode = 1'($urandom_range(0, 1));
            model_step();
            step();
            chk($sformatf("rand%0d", n), outs(), pack(m_pend(), m_time, m_busy, m_cmp, m_err, m_to));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nap_duration_entry.md
# nap_duration_entry

Parametrised keypad front end for the power-nap timer: turns keypad, `#` and `*` presses into a BCD nap duration (m…m:ss). It supports accumulating presets and direct digit entry, and hands the committed duration to the countdown block with a one-cycle completion strobe. It is the next generation of the single-shot preset selector: it adds configurable minute width, clear, validation and an entry timeout.

## Interface
Parameters:
- `MIN_DIGITS`, 1: number of BCD minute digits; total digits `ND = MIN_DIGITS + 2`.
- `TIMEOUT_CYCLES`, 16'd50000: idle cycles in ENTRY before auto-abort; 0 disables the timeout.

Ports:
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low.
- `en` input 1: entry enable; low forces IDLE.
- `direct_mode` input 1: 0 = preset accumulate, 1 = digit entry; sampled only in IDLE.
- `keypad` input 10: one-hot digit keys 0–9, level.
- `sharp` input 1: `#`, confirm.
- `star` input 1: `*`, clear.
- `pend_bcd` output 4*ND: pending value for display; digit0 = one_sec, digit1 = ten_sec, digit2+ = minutes.
- `time_bcd` output 4*ND: last committed duration.
- `complete_setting` output 1: one-cycle pulse when `time_bcd` updates.
- `entry_error` output 1: one-cycle pulse on rejected confirm.
- `timeout` output 1: one-cycle pulse on auto-abort.
- `busy` output 1: high in ENTRY.

## Operation
- Input qualification:
  - `keypad`, `sharp` and `star` are registered once. A press is a rising edge of each.
  - A keypad edge with more than one bit set is ignored.
  - Same-cycle priority: `star` > `sharp` > digit.
- States:
  - IDLE: `pend_bcd` = 0. Any qualified press with `en`=1 latches `direct_mode` into the mode register, goes to ENTRY, and the press is processed there in the same cycle.
  - ENTRY: processes presses per mode. `sharp` goes to DONE or back to ENTRY. `en`=0 aborts to IDLE. Timeout expiry aborts to IDLE.
  - DONE: one cycle; `time_bcd` ← `pend_bcd`, `complete_setting`=1, then IDLE.
- Preset mode:
  - Key 1 adds 0:05, key 2 adds 0:30, key 3 adds 1:00. Other digits are ignored.
  - BCD add with seconds carry at 60.
  - Saturates at the maximum value of 9…9:59.
- Direct mode:
  - Digit key shifts `pend_bcd` left one digit and inserts the key value into digit0.
  - The top digit is discarded.
  - No validation at shift time.
- `star` in ENTRY clears `pend_bcd` to 0 and stays in ENTRY.
- Confirm:
  - If ten_sec > 5 or `pend_bcd` = 0: pulse `entry_error`, stay in ENTRY with `pend_bcd` unchanged.
  - Otherwise go to DONE.
- Abort (`en` low or timeout): `pend_bcd` ← 0, `time_bcd` retained. `timeout` pulses only on timer expiry.
- Idle counter: cleared by any qualified press and on entry to ENTRY. Expires when it reaches `TIMEOUT_CYCLES`.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `pend_bcd`, `time_bcd`, all pulses, `busy`, the idle counter and the edge registers are 0.
- Reset mid-entry discards everything, including `time_bcd`.
- Latency: input sampled at edge k, edge detected at edge k+1, `pend_bcd` updated at edge k+1.
- `sharp` detected at edge k+1: state is DONE at k+1, `time_bcd` and `complete_setting` valid at k+2, IDLE at k+2.
- `complete_setting`, `entry_error` and `timeout` are exactly one cycle wide. They are never asserted simultaneously.
- A key held for many cycles counts as one press.
- `en` dropping in the same cycle as a `sharp` edge: the abort wins and no commit happens.

## Structure
- Package `nap_pkg` holds:
  - the state enum (IDLE, ENTRY, DONE);
  - the BCD digit typedef;
  - preset constants `PRESET_5S`, `PRESET_30S`, `PRESET_1M`;
  - the key index constants.
- Sub-module `bcd_time_adder`: combinational, parametrised on `MIN_DIGITS`. It adds a preset in m:ss BCD and saturates.

## Test plan
- Preset mode; press 1, 2, 3, 1; then `#` → `pend_bcd` = 1:40, `time_bcd` = 1:40, one `complete_setting` pulse two cycles after `#`.
- Direct mode, `MIN_DIGITS`=1; keys 2, 4, 5 then `#` → 2:45 committed. Keys 1, 7, 0 then `#` → `entry_error`, `pend_bcd` = 1:70 retained.
- Preset mode; press key 3 twelve times → saturate at 9:59. Then `*` → 0:00, still busy.
- `TIMEOUT_CYCLES`=8; press key 1 then idle for 8 cycles → `timeout` pulse, IDLE, `pend_bcd` = 0, prior `time_bcd` unchanged.
- `keypad` = 10'b0000000110 edge → ignored. Key 1 held 20 cycles → adds 0:05 once.
- Assert `reset`=0 during ENTRY with a committed value present → all outputs 0 on the next edge.
